// File: rtl/imem_loader_if.sv
// imem_loader_if: UART receive line in, imem write side and core control out.
interface imem_loader_if #(
    parameter int ADDR_W = 12
);
    logic              rxd;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              core_rst;
    logic              done;
    logic              err;
    modport master (input rxd, output we, addr, wdata, core_rst, done, err);
    modport slave  (output rxd, input we, addr, wdata, core_rst, done, err);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: UART 8N1 loader writing a word-count-prefixed image into imem, holding the core in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR-of-payload checksum byte.
module imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 12
) (
    input logic           clk,
    input logic           rst,
    imem_loader_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_e;
    typedef enum logic [2:0] {HDR0, HDR1, WORD, WLAST, CSUM, FIN, ERR} ld_e;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam ld_e TAIL = CSUM;
    logic [7:0] csum_q;
`else
    localparam ld_e TAIL = FIN;
`endif
    logic [1:0]        sync_q;
    logic              rx, rx_prev_q;
    rx_e               rx_st_q, rx_st_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        sh_q, sh_d;
    logic              byte_vld, frame_err;
    ld_e               st_q, st_d;
    logic [15:0]       n_q, n_d, idx_q, idx_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       word_q, word_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d, in_range;

    assign rx       = sync_q[1];
    assign in_range = (idx_q >> ADDR_W) == 16'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            rx_st_q   <= R_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
        end else begin
            sync_q    <= {sync_q[0], bus.rxd};
            rx_prev_q <= rx;
            rx_st_q   <= rx_st_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
        end
    end

    // Start sampled mid-bit, then every full bit period; stop sample yields byte or framing error.
    always_comb begin
        rx_st_d   = rx_st_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        sh_d      = sh_q;
        byte_vld  = 1'b0;
        frame_err = 1'b0;
        case (rx_st_q)
            R_IDLE: begin
                cnt_d   = '0;
                rx_st_d = (rx_prev_q && !rx) ? R_START : R_IDLE;
            end
            R_START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                rx_st_d = rx ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt_q == FULL) begin
                cnt_d   = '0;
                sh_d    = {rx, sh_q[7:1]};
                bit_d   = bit_q + 3'd1;
                rx_st_d = (bit_q == 3'd7) ? R_STOP : R_DATA;
            end
            default: if (cnt_q == FULL) begin
                cnt_d     = '0;
                rx_st_d   = R_IDLE;
                byte_vld  = rx;
                frame_err = !rx;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= HDR0;
            n_q     <= '0;
            idx_q   <= '0;
            k_q     <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            st_q    <= st_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            word_q  <= word_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk)
        csum_q <= rst ? 8'd0 : (st_q == WORD && byte_vld) ? csum_q ^ sh_q : csum_q;
`endif

    // Words past the memory are still counted so the image length is honoured.
    always_comb begin
        st_d    = st_q;
        n_d     = n_q;
        idx_d   = idx_q;
        k_d     = k_q;
        word_d  = word_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (frame_err && st_q != FIN) st_d = ERR;
        else case (st_q)
            HDR0: if (byte_vld) begin
                n_d[7:0] = sh_q;
                st_d     = HDR1;
            end
            HDR1: if (byte_vld) begin
                n_d[15:8] = sh_q;
                st_d      = (n_d == 16'd0) ? TAIL : WORD;
            end
            WORD: if (byte_vld) begin
                word_d[8*k_q +: 8] = sh_q;
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    we_d    = in_range;
                    addr_d  = in_range ? idx_q[ADDR_W-1:0] : addr_q;
                    wdata_d = in_range ? word_d : wdata_q;
                    idx_d   = idx_q + 16'd1;
                    st_d    = (idx_d == n_q) ? WLAST : WORD;
                end
            end
            WLAST: st_d = TAIL;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: if (byte_vld) st_d = (sh_q == csum_q) ? FIN : ERR;
`endif
            default: ;
        endcase
    end

    always_comb begin
        bus.core_rst = st_q != FIN;
        bus.done     = st_q == FIN;
        bus.err      = st_q == ERR;
    end

    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table vectors, corner sequences and randomized images against a stream-level model.
module tb_imem_loader;
    localparam int CPB   = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    typedef struct {
        int          n;
        int          nw;
        int          bad;
        int          pre;
        logic [31:0] base;
        logic [31:0] inc;
        int          exp_w;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0, passed = 0, cyc = 0, last_we = 0, done_cyc = 0;
    bit          done_seen = 1'b0;
    logic [31:0] words [0:31];
    int          wa[$];
    logic [31:0] wd[$];
    vec_t        tv [10];

    imem_loader_if #(.ADDR_W(AW)) bus ();
    imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            wa.delete();
            wd.delete();
            done_seen = 1'b0;
        end else begin
            if (bus.we === 1'b1) begin
                wa.push_back(int'(bus.addr));
                wd.push_back(bus.wdata);
                last_we = cyc;
                check("we_with_core_running", 32'(bus.core_rst), 32'd1);
            end
            if (bus.done === 1'b1 && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        logic [9:0] f;
        f = {~bad_stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.rxd = f[i];
            tick(CPB);
        end
        bus.rxd = 1'b1;
        tick(2);
    endtask

    task automatic run(input string tag, input int n, input int nw, input int bad, input int pre,
                       input bit bad_cs, input int exp_w, input bit exp_done, input bit exp_err);
        logic [7:0]  s[$];
        logic [7:0]  x, b;
        logic [15:0] n16;
        n16 = 16'(n);
        x = '0;
        s.push_back(n16[7:0]);
        s.push_back(n16[15:8]);
        for (int i = 0; i < nw; i++)
            for (int k = 0; k < 4; k++) begin
                b = words[i][8*k +: 8];
                s.push_back(b);
                x ^= b;
            end
        if (CS == 1) s.push_back(bad_cs ? x ^ 8'h01 : x);
        bus.rxd = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check({tag, ":rst_we"}, 32'(bus.we), 32'd0);
        check({tag, ":rst_addr"}, 32'(bus.addr), 32'd0);
        check({tag, ":rst_wdata"}, bus.wdata, 32'd0);
        check({tag, ":rst_core_rst"}, 32'(bus.core_rst), 32'd1);
        check({tag, ":rst_done"}, 32'(bus.done), 32'd0);
        check({tag, ":rst_err"}, 32'(bus.err), 32'd0);
        if (pre == 1) begin
            bus.rxd = 1'b0;
            tick(1);
            bus.rxd = 1'b1;
            tick(10);
        end
        if (pre == 2) begin
            bus.rxd = 1'b0;
            tick(10);
            bus.rxd = 1'b1;
            rst = 1'b1;
            tick(2);
            rst = 1'b0;
            tick(4);
        end
        foreach (s[i]) send_byte(s[i], i == bad);
        tick(10);
        check({tag, ":n_writes"}, wa.size(), exp_w);
        for (int i = 0; i < wa.size() && i < exp_w; i++) begin
            check($sformatf("%s:addr%0d", tag, i), wa[i], i);
            check($sformatf("%s:data%0d", tag, i), wd[i], words[i]);
        end
        check({tag, ":done"}, 32'(bus.done), 32'(exp_done));
        check({tag, ":err"}, 32'(bus.err), 32'(exp_err));
        check({tag, ":core_rst"}, 32'(bus.core_rst), 32'(!exp_done));
        check({tag, ":we_idle"}, 32'(bus.we), 32'd0);
        if (exp_w > 0) begin
            check({tag, ":addr_hold"}, 32'(bus.addr), exp_w - 1);
            check({tag, ":wdata_hold"}, bus.wdata, words[exp_w-1]);
        end
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (exp_done && exp_w == n && n > 0) check({tag, ":done_latency"}, done_cyc - last_we, 1);
`endif
    endtask

    initial begin
        bus.rxd = 1'b1;
        tv[0] = '{2,  2,  -1, 0, 32'h12345678, 32'hCC796877, 2,  1'b1, 1'b0};
        tv[1] = '{0,  0,  -1, 0, 32'h0,        32'h0,        0,  1'b1, 1'b0};
        tv[2] = '{1,  2,  2,  0, 32'h11111111, 32'h01010101, 0,  1'b0, 1'b1};
        tv[3] = '{17, 17, -1, 0, 32'h0,        32'h1,        16, 1'b1, 1'b0};
        tv[4] = '{1,  1,  -1, 1, 32'hA5A50F0F, 32'h0,        1,  1'b1, 1'b0};
        tv[5] = '{1,  1,  -1, 0, 32'h44332211, 32'h0,        1,  1'b1, 1'b0};
        tv[6] = '{3,  2,  -1, 0, 32'hCAFE0000, 32'h00010001, 2,  1'b0, 1'b0};
        tv[7] = '{1,  1,  -1, 2, 32'h0BADF00D, 32'h0,        1,  1'b1, 1'b0};
        tv[8] = '{1,  1,  1,  0, 32'h87654321, 32'h0,        0,  1'b0, 1'b1};
        tv[9] = '{2,  2,  7,  0, 32'h01020304, 32'h10101010, 1,  1'b0, 1'b1};
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 32; i++) words[i] = tv[t].base + tv[t].inc * 32'(i);
            run($sformatf("vec%0d", t), tv[t].n, tv[t].nw, tv[t].bad, tv[t].pre, 1'b0,
                tv[t].exp_w, tv[t].exp_done, tv[t].exp_err);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        words[0] = 32'h44332211;
        run("bad_csum", 1, 1, -1, 0, 1'b1, 1, 1'b0, 1'b1);
`endif
        for (int r = 0; r < 6; r++) begin
            int n, needed, bad, ew;
            bit err;
            n = int'($urandom_range(0, 20));
            for (int i = 0; i < 32; i++) words[i] = $urandom();
            needed = 2 + 4 * n + CS;
            bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, needed - 1)) : -1;
            err = bad >= 0;
            ew = 0;
            for (int i = 0; i < n && i < DEPTH; i++) if (!err || 2 + 4 * i + 3 < bad) ew++;
            run($sformatf("rnd%0d_n%0d_bad%0d", r, n, bad), n, n, bad, 0, 1'b0, ew, !err, err);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Serial program loader: receives a program image over a UART line and writes it word-by-word into the instruction memory write port.
- Holds the processor core in reset until the image is complete.
- Sits between the board UART pin and the imem write side (addr/in/we). It is the writer counterpart to the core's read-only fetch port.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- ADDR_W, 12, imem word-address width (4096 words).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- rxd  input  1  UART receive line, idle high, 8N1, LSB first; asynchronous to clk.
- we  output  1  imem write enable, one-cycle pulse per word.
- addr  output  ADDR_W  imem word address of current write.
- wdata  output  32  imem write data.
- core_rst  output  1  reset to processor; high until load completes.
- done  output  1  sticky; image loaded successfully.
- err  output  1  sticky; framing or checksum error.

Behaviour:
- Reset values: we=0, addr=0, wdata=0, core_rst=1, done=0, err=0. The FSM goes to HDR0 and the RX sampler goes to IDLE. Reset mid-frame discards everything.
- rxd passes through a 2-FF synchronizer, which adds 2 cycles of latency. Synchronizer flops reset to 1.
- RX sampler, states IDLE, START, DATA, STOP:
  - IDLE->START on a synced 1->0 transition.
  - START re-samples at CLKS_PER_BIT/2. If the line is high, it is a glitch: return to IDLE. Otherwise go to DATA.
  - DATA samples 8 bits, each CLKS_PER_BIT apart, LSB first.
  - STOP samples after one more CLKS_PER_BIT. If high, byte_vld pulses for 1 cycle. If low, it is a framing error.
  - Then return to IDLE. A new start bit is accepted from the cycle after the STOP sample.
- Byte protocol:
  - 2-byte little-endian word count N.
  - Then N words, 4 bytes each, little-endian.
  - Then 1 checksum byte, only with the optional feature.
- Loader FSM:
  - HDR0: latch N[7:0] on byte_vld. Go to HDR1.
  - HDR1: latch N[15:8]. If N==0, go to FIN; else go to WORD.
  - WORD: shift each byte into bits [8*k+:8], where k is the byte index 0..3, a 2-bit counter. On the 4th byte, the next cycle drives we=1, wdata=word, addr=word index.
    - The word index then increments.
    - When the index reaches N, go to FIN.
  - FIN: core_rst<=0 and done<=1 on the cycle after the final we pulse, or the cycle after HDR1 when N==0. Stays in FIN until rst and ignores all further bytes.
  - ERR: err<=1, core_rst stays 1, no further writes. Exit only via rst.
- Word indices >= 2**ADDR_W are consumed and counted but not written (we stays 0). addr never wraps onto low memory.
- A framing error in any non-FIN state goes to ERR immediately. It takes priority over a concurrent byte completion.
- we is never high while core_rst=0.
- addr and wdata hold their last values between pulses.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the N-th word, the FSM enters CSUM and expects 1 byte equal to the XOR of all 4N payload bytes. Header bytes are excluded.
  - Match -> FIN. Mismatch -> ERR.
  - Words are still written as they arrive. core_rst is released only on a checksum match, 1 cycle after the checksum byte_vld.
  - When N==0, the expected checksum byte is 0x00.
- Undefined: no CSUM state. The FSM goes to FIN directly after the last word.

Test Plan (CLKS_PER_BIT=4, ADDR_W=4):
- Send 02 00 | 78 56 34 12 | EF BE AD DE -> we pulses twice: (addr 0, 0x12345678) then (addr 1, 0xDEADBEEF). core_rst falls and done rises 1 cycle after the 2nd pulse. err=0.
- Send 00 00 -> no we pulse. done=1 and core_rst=0 one cycle after the 2nd byte.
- Send 01 00, then a byte with stop bit driven low -> err=1, core_rst remains 1, no we pulse. A later valid word produces no write. Asserting rst returns to HDR0, with core_rst=1 and err=0.
- N=17 with words 0..16 -> 16 writes at addr 0..15. The 17th word produces no we pulse. done=1 after the 17th word.
- 1-cycle low glitch on rxd during HDR0 -> no byte_vld and state unchanged. The following valid header is accepted normally.
- With IMEM_LOADER_CHECKSUM_EN: send 01 00 11 22 33 44 44 -> write (0, 0x44332211), then done=1. With final byte 45 instead -> err=1 and core_rst=1, but the word write still occurred.
